// File: rtl/idx_gather_agu.sv
// Gather address-generation unit: walks a contiguous range of index-RAM entries
// and streams base + (index << shift) byte addresses over a valid/ready port.
module idx_gather_agu #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16,
   parameter int OUT_AW     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] cfg_start_idx,
   input  logic [ADDR_WIDTH:0]   cfg_count,
   input  logic [OUT_AW-1:0]     cfg_base,
   input  logic [2:0]            cfg_shift,
   output logic [ADDR_WIDTH-1:0] idx_raddr,
   input  logic [DATA_WIDTH-1:0] idx_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_AW-1:0]     out_addr,
   output logic                  out_last,
   output logic [ADDR_WIDTH:0]   out_seq,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   rdPtr_q;
   logic [ADDR_WIDTH:0]     remaining_q;
   logic [ADDR_WIDTH:0]     issued_q;
   logic [OUT_AW-1:0]       base_q;
   logic [2:0]              shift_q;
   logic                    outValid_q;
   logic [OUT_AW-1:0]       outAddr_q;
   logic                    outLast_q;
   logic [ADDR_WIDTH:0]     outSeq_q;
   logic                    busy_q;
   logic                    done_q;

   logic [OUT_AW-1:0]       addr_d;
   logic                    accept;
   logic                    load;

   // A new beat may load whenever the output slot is empty or being drained this cycle.
   always_comb begin
      addr_d = base_q + (OUT_AW'(idx_rdata) << shift_q);
      accept = outValid_q && out_ready;
      load   = (state_q == RUN) && (remaining_q != '0) && (!outValid_q || out_ready);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rdPtr_q     <= '0;
         remaining_q <= '0;
         issued_q    <= '0;
         base_q      <= '0;
         shift_q     <= '0;
         outValid_q  <= 1'b0;
         outAddr_q   <= '0;
         outLast_q   <= 1'b0;
         outSeq_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  rdPtr_q     <= cfg_start_idx;
                  remaining_q <= cfg_count;
                  issued_q    <= '0;
                  base_q      <= cfg_base;
                  shift_q     <= cfg_shift;
                  if (cfg_count != '0) begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (load) begin
                  outAddr_q   <= addr_d;
                  outValid_q  <= 1'b1;
                  outLast_q   <= (remaining_q == (ADDR_WIDTH+1)'(1));
                  outSeq_q    <= issued_q;
                  issued_q    <= issued_q + (ADDR_WIDTH+1)'(1);
                  rdPtr_q     <= rdPtr_q + ADDR_WIDTH'(1);
                  remaining_q <= remaining_q - (ADDR_WIDTH+1)'(1);
               end else if (accept) begin
                  outValid_q <= 1'b0;
               end
               // Once the final beat drains, the one-cycle done pulse lives in FIN.
               if (accept && outLast_q) begin
                  state_q <= FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            FIN: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign idx_raddr = rdPtr_q;
   assign out_valid = outValid_q;
   assign out_addr  = outAddr_q;
   assign out_last  = outLast_q;
   assign out_seq   = outSeq_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: doc/idx_gather_agu.md
Name: idx_gather_agu

Overview:
- Gather address-generation unit directly downstream of the index RAM's read port.
- On a start command it walks a contiguous range of index-RAM entries and turns each index into a scaled byte address: `base + (idx << shift)`.
- Addresses stream out on a valid/ready interface to the gather data-memory requester.
- Sustains one address per cycle when the consumer is ready.

Parameters:
- ADDR_WIDTH, 10, index-RAM address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, 16, index width, i.e. width of `idx_rdata`.
- OUT_AW, 32, width of the generated address.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle command pulse; sampled only in IDLE.
- cfg_start_idx  input  ADDR_WIDTH  first index-RAM entry to read.
- cfg_count  input  ADDR_WIDTH+1  number of entries, 0..2^ADDR_WIDTH.
- cfg_base  input  OUT_AW  base byte address.
- cfg_shift  input  3  element-size shift, 0..7.
- idx_raddr  output  ADDR_WIDTH  index-RAM read address; the RAM returns data combinationally.
- idx_rdata  input  DATA_WIDTH  index-RAM read data.
- out_valid  output  1  address beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_addr  output  OUT_AW  gathered address.
- out_last  output  1  marks the final beat of the command.
- out_seq  output  ADDR_WIDTH+1  beat number within the command, starting at 0.
- busy  output  1  high from the cycle after an accepted start until the cycle `done` pulses.
- done  output  1  one-cycle completion pulse.

Behaviour:
- **Reset** (`rst`=1 at an edge) forces IDLE and clears:
  - `out_valid`, `out_last`, `out_seq`, `busy`, `done` = 0
  - `idx_raddr` = 0, `out_addr` = 0
- **Reset mid-command:** the command is abandoned, no `done` pulse is produced, and any pending beat is dropped.
- **States:** IDLE, RUN, FIN.
- **IDLE:**
  - `start`=1 with `cfg_count`>0: latch all cfg inputs, set `rd_ptr` = `cfg_start_idx`, `remaining` = `cfg_count`, go to RUN.
  - `start`=1 with `cfg_count`=0: go to FIN; no beats are emitted.
- **RUN:**
  - `idx_raddr` = `rd_ptr`.
  - Load condition: `remaining`>0 and (`out_valid`=0 or `out_ready`=1).
  - On load:
    - `out_addr` ← `cfg_base` + (zero-extend(`idx_rdata`) << `cfg_shift`), truncated to OUT_AW (modular).
    - `out_valid` ← 1.
    - `out_last` ← (`remaining`==1).
    - `out_seq` ← beats issued so far.
    - `rd_ptr` increments modulo 2^ADDR_WIDTH (wraps past the top entry).
    - `remaining` decrements.
  - If `out_valid`=1 and `out_ready`=1 with nothing left to load: `out_valid` ← 0.
  - Go to FIN when the beat with `out_last`=1 is accepted.
- **FIN:** `done`=1 for exactly one cycle, `busy`=0, then IDLE.
- **`start` outside IDLE** is ignored; cfg inputs are don't-care outside the start cycle.
- **Latency:** start sampled at edge E0 → RUN from E0 → first `out_valid`=1 after E1. With `out_ready` held high:
  - one beat per cycle;
  - `done` asserts the cycle after the last handshake.
- **Output stability:** while `out_valid`=1 and `out_ready`=0, `out_addr`, `out_last` and `out_seq` hold stable, and `rd_ptr` does not advance.
- **Simultaneous handshake and load** (`out_valid`=1, `out_ready`=1, `remaining`>0): the next beat loads the same cycle, with no bubble.
- **Full range:** `cfg_count` = 2^ADDR_WIDTH visits every entry exactly once, in order, starting at `cfg_start_idx`.
- **Index RAM writes during RUN** are visible as of the cycle the entry is read; there is no snapshot.

Test Plan:
- Basic walk: RAM[0..3] = {5, 0, 7, 2}, start_idx=0, count=4, base=0x1000, shift=2, `out_ready`=1 → beats 0x1014, 0x1000, 0x101C, 0x1008 on 4 consecutive cycles starting 2 cycles after start; `out_seq` 0..3; `out_last` on beat 3; `done` the next cycle.
- Backpressure: same config, `out_ready` toggling 1,0,0,1,… → every beat holds stable while stalled; no beat lost or duplicated; `idx_raddr` frozen during stalls.
- Wrap-around: ADDR_WIDTH=10, start_idx=1022, count=4 → reads entries 1022, 1023, 0, 1 in that order.
- Zero count and ignored start: count=0 → `done` pulse, `out_valid` never asserts. A second `start` pulsed while busy → no effect; beat count equals the first command's count.
- Arithmetic extremes: idx=0xFFFF, shift=7, base=0xFFFF_F000 → `out_addr` = (0xFFFF_F000 + 0x7F_FF80) mod 2^32 = 0x007F_EF80.
- Reset mid-operation: assert `rst` during beat 2 of an 8-beat command → next cycle all outputs are 0, no `done`; a fresh start then runs a full, correct sequence.
